// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and shared-memory bus of mem_arbiter
// signals: req0/addr0/ack0/rdata0 (fetch), req1/we1/addr1/wdata1/ack1/rdata1 (load/store),
//          mem_en/mem_we/mem_addr/mem_wdata/mem_rdata (shared memory), busy (arbiter not idle)
// modports: slave = arbiter side, master = requesters plus memory side
interface mem_arbiter_if #(
   parameter int AW = 8
);
   logic          req0;
   logic [AW-1:0] addr0;
   logic          ack0;
   logic [31:0]   rdata0;
   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [31:0]   wdata1;
   logic          ack1;
   logic [31:0]   rdata1;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          busy;
   modport slave (
      input  req0, addr0, req1, we1, addr1, wdata1, mem_rdata,
      output ack0, rdata0, ack1, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy
   );
   modport master (
      output req0, addr0, req1, we1, addr1, wdata1, mem_rdata,
      input  ack0, rdata0, ack1, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between a read-only fetch port (0) and a load/store port (1)
// ports: clk, rst (synchronous, active-high), bus (mem_arbiter_if.slave)
// params: MEM_LAT memory read latency 1..7, AW address width
// ARB_FIXED_PRIO_EN: when defined port 1 wins every contention; otherwise round-robin
module mem_arbiter #(
   parameter int MEM_LAT = 1,
   parameter int AW      = 8
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          win_q, win_d, last_q, last_d, g1;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d, en_q, en_d, ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
   logic [31:0]   wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   // last_q is the port granted last; port 1 wins contention only if port 0 was granted last
`ifdef ARB_FIXED_PRIO_EN
   assign g1 = bus.req1;
`else
   assign g1 = bus.req1 && (!bus.req0 || !last_q);
`endif
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      win_d    = win_q;
      last_d   = last_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         IDLE: if (bus.req0 || bus.req1) begin
            win_d   = g1;
            last_d  = g1;
            addr_d  = g1 ? bus.addr1 : bus.addr0;
            we_d    = g1 && bus.we1;
            wdata_d = g1 ? bus.wdata1 : wdata_q;
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d   = 3'(MEM_LAT);
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = DONE;
               if (!we_q && win_q) rdata1_d = bus.mem_rdata;
               if (!we_q && !win_q) rdata0_d = bus.mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
      // strobes are decoded from the next state so they come straight out of flops
      en_d   = state_d == ISSUE;
      ack0_d = state_d == DONE && !win_d;
      ack1_d = state_d == DONE && win_d;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         win_q    <= 1'b0;
         last_q   <= 1'b1;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         en_q     <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         win_q    <= win_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         en_q     <= en_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         busy_q   <= busy_d;
      end
   end
   assign bus.mem_en    = en_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter, instance a (MEM_LAT=1) and instance b (MEM_LAT=3)
module tb_mem_arbiter;
   typedef struct {
      logic        port;
      logic [31:0] data;
      int          at;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          en_cnt[2] = '{0, 0};
   logic        st_we;
   logic [7:0]  st_addr;
   logic [31:0] st_wdata;
   exp_t        exp_q[2][$];
   logic [255:0] wv = '0;
   logic [31:0] wmem[256];
   logic [31:0] pa[7], pb[7];
   mem_arbiter_if #(.AW(8)) ia();
   mem_arbiter_if #(.AW(8)) ib();
   mem_arbiter #(.MEM_LAT(1), .AW(8)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
   mem_arbiter #(.MEM_LAT(3), .AW(8)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));
   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // memory contents: addr 3 holds 8C010000, others 10000000|addr unless written
   function automatic logic [31:0] rd(input logic [7:0] a);
      return wv[a] ? wmem[a] : (a == 8'd3 ? 32'h8C010000 : 32'h10000000 | 32'(a));
   endfunction
   // read data travels down a pipe; stage L-1 is valid L cycles after the mem_en cycle
   always @(posedge clk) begin
      if (ia.mem_en && ia.mem_we) begin
         wmem[ia.mem_addr] <= ia.mem_wdata;
         wv[ia.mem_addr]   <= 1'b1;
      end
      pa[0] <= (ia.mem_en && !ia.mem_we) ? rd(ia.mem_addr) : 32'hDEADBEEF;
      pb[0] <= (ib.mem_en && !ib.mem_we) ? rd(ib.mem_addr) : 32'hDEADBEEF;
      for (int i = 1; i < 7; i++) begin
         pa[i] <= pa[i-1];
         pb[i] <= pb[i-1];
      end
   end
   assign ia.mem_rdata = pa[0];
   assign ib.mem_rdata = pb[2];
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", n, act, exp);
      end
   endtask
   task automatic push(input int k, input logic p, input logic [31:0] d, input int at);
      exp_t e;
      e.port = p;
      e.data = d;
      e.at   = at;
      exp_q[k].push_back(e);
   endtask
   task automatic check_ack(input int k, input logic a0, input logic a1, input logic [31:0] r0,
                            input logic [31:0] r1);
      exp_t e;
      if (!(a0 || a1)) return;
      checks++;
      if (exp_q[k].size() == 0) begin
         errors++;
         $display("FAIL ack_inst%0d: got ack0=%b ack1=%b at cycle %0d, required no ack", k, a0, a1, cyc);
         return;
      end
      e = exp_q[k].pop_front();
      if (a0 == e.port || a1 != e.port || cyc != e.at || (e.port ? r1 : r0) !== e.data) begin
         errors++;
         $display("FAIL ack_inst%0d: got ack0=%b ack1=%b cycle %0d data %h, required port %0d cycle %0d data %h",
                  k, a0, a1, cyc, e.port ? r1 : r0, e.port, e.at, e.data);
      end
   endtask
   // monitor: every ack is matched against the scoreboard; strobes are counted and recorded
   always @(negedge clk) begin
      check_ack(0, ia.ack0, ia.ack1, ia.rdata0, ia.rdata1);
      check_ack(1, ib.ack0, ib.ack1, ib.rdata0, ib.rdata1);
      if (ia.mem_en) begin
         en_cnt[0]++;
         st_we    = ia.mem_we;
         st_addr  = ia.mem_addr;
         st_wdata = ia.mem_wdata;
      end
      if (ib.mem_en) en_cnt[1]++;
   end
   // requester handshake; called at a negedge, returns at a negedge after dropping req
   task automatic acc(input int k, input logic p, input logic we, input logic [7:0] a,
                      input logic [31:0] wd);
      bit got = 0;
      if (k == 1) begin
         ib.req0 = 1'b1;
         ib.addr0 = a;
      end else if (p) begin
         ia.req1 = 1'b1;
         ia.we1 = we;
         ia.addr1 = a;
         ia.wdata1 = wd;
      end else begin
         ia.req0 = 1'b1;
         ia.addr0 = a;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = k == 1 ? ib.ack0 : (p ? ia.ack1 : ia.ack0);
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL timeout_inst%0d_port%0d: got no ack, required ack", k, p);
      end
      @(posedge clk);
      #1;
      if (k == 1) ib.req0 = 1'b0;
      else if (p) ia.req1 = 1'b0;
      else ia.req0 = 1'b0;
      @(negedge clk);
   endtask
   task automatic reset_a();
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1);
   end
   initial begin
      int  n, acks;
      logic p;
      {ia.req0, ia.req1, ia.we1, ib.req0, ib.req1, ib.we1} = '0;
      {ia.addr0, ia.addr1, ib.addr0, ib.addr1} = '0;
      {ia.wdata1, ib.wdata1} = '0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      chk("rst_ctrl", {27'b0, ia.ack0, ia.ack1, ia.mem_en, ia.mem_we, ia.busy}, 0);
      chk("rst_rdata0", ia.rdata0, 0);
      chk("rst_rdata1", ia.rdata1, 0);
      chk("rst_mem_addr", {24'b0, ia.mem_addr}, 0);
      chk("rst_mem_wdata", ia.mem_wdata, 0);
      // single fetch: ack in the 3rd cycle after the sampling edge
      n = en_cnt[0];
      push(0, 1'b0, 32'h8C010000, cyc + 3);
      acc(0, 1'b0, 1'b0, 8'd3, 0);
      chk("fetch_strobes", en_cnt[0] - n, 1);
      // contention right after reset: port 0 first, port 1 one access (4 cycles) later
      reset_a();
      n = en_cnt[0];
      push(0, 1'b0, 32'h8C010000, cyc + 3);
      push(0, 1'b1, 32'h10000002, cyc + 7);
      fork
         acc(0, 1'b0, 1'b0, 8'd3, 0);
         acc(0, 1'b1, 1'b0, 8'd2, 0);
      join
      chk("contend_strobes", en_cnt[0] - n, 2);
      // store: rdata1 keeps the previous load data
      push(0, 1'b1, 32'h10000002, cyc + 3);
      acc(0, 1'b1, 1'b1, 8'd1, 32'h0000000A);
      chk("store_we", {31'b0, st_we}, 1);
      chk("store_addr", {24'b0, st_addr}, 1);
      chk("store_wdata", st_wdata, 32'h0000000A);
      push(0, 1'b0, 32'h0000000A, cyc + 3);
      acc(0, 1'b0, 1'b0, 8'd1, 0);
      // both ports request continuously for 4 grants
      reset_a();
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
         p = 1'b1;
`else
         p = i % 2 == 1;
`endif
         push(0, p, p ? 32'h10000002 : 32'h8C010000, cyc + 3 + 4 * i);
      end
      ia.req0 = 1'b1;
      ia.addr0 = 8'd3;
      ia.req1 = 1'b1;
      ia.we1 = 1'b0;
      ia.addr1 = 8'd2;
      acks = 0;
      for (int i = 0; i < 60 && acks < 4; i++) begin
         @(negedge clk);
         if (ia.ack0 || ia.ack1) acks++;
      end
      if (acks < 4) begin
         checks++;
         errors++;
         $display("FAIL timeout_stream: got %0d acks, required 4", acks);
      end
      @(posedge clk);
      #1;
      ia.req0 = 1'b0;
      ia.req1 = 1'b0;
      @(negedge clk);
      // instance b: reset during WAIT aborts the read
      n = en_cnt[1];
      ib.req0 = 1'b1;
      ib.addr0 = 8'd3;
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      ib.req0 = 1'b0;
      @(negedge clk);
      rst_b = 1'b0;
      chk("abort_busy", {31'b0, ib.busy}, 0);
      chk("abort_ack0", {31'b0, ib.ack0}, 0);
      repeat (6) @(negedge clk);
      chk("abort_strobes", en_cnt[1] - n, 1);
      push(1, 1'b0, 32'h8C010000, cyc + 5);
      acc(1, 1'b0, 1'b0, 8'd3, 0);
      repeat (3) @(negedge clk);
      chk("sb_empty_a", exp_q[0].size(), 0);
      chk("sb_empty_b", exp_q[1].size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
